// File: rtl/seg7_digit_driver.sv
`default_nettype none
// ============================================================================
// Module  : seg7_digit_driver
// Brief   : 4-digit 7-segment driver with frame-synchronous value shadowing,
//           anti-ghosting blanking and illegal-select detection.
// Revision: 1.0
// ============================================================================
module seg7_digit_driver #(
   parameter int BLANK_CYCLES = 3,
   parameter bit LZB          = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  dig_sel,
   input  logic [15:0] val_data,
   input  logic [3:0]  val_dp,
   input  logic        val_valid,
   output logic        val_ready,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic        frame_start,
   output logic        sel_err
);

   localparam logic [1:0] c_S_IDLE  = 2'd0;
   localparam logic [1:0] c_S_BLANK = 2'd1;
   localparam logic [1:0] c_S_SHOW  = 2'd2;
   localparam logic [7:0] c_BLANK   = 8'(BLANK_CYCLES);

   logic [3:0]  s1_q, s2_q, s3_q;
   logic [15:0] pend_data_q, pend_data_d, shadow_q, shadow_d;
   logic [3:0]  pend_dp_q, pend_dp_d, shadow_dp_q, shadow_dp_d;
   logic        pend_full_q, pend_full_d, val_ready_q;
   logic [1:0]  state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        err_q, err_d;
   logic [3:0]  an_q, an_d;
   logic [6:0]  seg_q, seg_d;
   logic        dp_q, dp_d, frame_start_q;
   logic        w_chg, w_legal, w_frame_evt, w_accept;
   logic [1:0]  w_dig_idx;
   logic [3:0]  w_lz;

   function automatic logic [6:0] f_hex7(input logic [3:0] n);
      case (n)
         4'h0: f_hex7 = 7'h40;  4'h1: f_hex7 = 7'h79;
         4'h2: f_hex7 = 7'h24;  4'h3: f_hex7 = 7'h30;
         4'h4: f_hex7 = 7'h19;  4'h5: f_hex7 = 7'h12;
         4'h6: f_hex7 = 7'h02;  4'h7: f_hex7 = 7'h78;
         4'h8: f_hex7 = 7'h00;  4'h9: f_hex7 = 7'h10;
         4'hA: f_hex7 = 7'h08;  4'hB: f_hex7 = 7'h03;
         4'hC: f_hex7 = 7'h46;  4'hD: f_hex7 = 7'h21;
         4'hE: f_hex7 = 7'h06;  default: f_hex7 = 7'h0E;
      endcase
   endfunction

   assign w_chg       = (s2_q != s3_q);
   assign w_frame_evt = w_chg && (s2_q == 4'b1110);
   assign w_accept    = val_valid && val_ready_q;

   always_comb begin
      w_legal   = 1'b1;
      w_dig_idx = 2'd0;
      case (s2_q)
         4'b1110: w_dig_idx = 2'd0;
         4'b1101: w_dig_idx = 2'd1;
         4'b1011: w_dig_idx = 2'd2;
         4'b0111: w_dig_idx = 2'd3;
         default: w_legal   = 1'b0;
      endcase
   end

   // Shadow swaps only at frame start so a value never tears across a scan.
   always_comb begin
      shadow_d    = shadow_q;
      shadow_dp_d = shadow_dp_q;
      pend_full_d = pend_full_q;
      pend_data_d = pend_data_q;
      pend_dp_d   = pend_dp_q;
      if (w_frame_evt && pend_full_q) begin
         shadow_d    = pend_data_q;
         shadow_dp_d = pend_dp_q;
         pend_full_d = 1'b0;
      end
      if (w_accept) begin
         pend_data_d = val_data;
         pend_dp_d   = val_dp;
         pend_full_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         s1_q          <= 4'hF;
         s2_q          <= 4'hF;
         s3_q          <= 4'hF;
         pend_data_q   <= 16'h0;
         pend_dp_q     <= 4'h0;
         pend_full_q   <= 1'b0;
         shadow_q      <= 16'h0;
         shadow_dp_q   <= 4'h0;
         val_ready_q   <= 1'b1;
         frame_start_q <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         s1_q          <= dig_sel;
         s2_q          <= s1_q;
         s3_q          <= s2_q;
         pend_data_q   <= pend_data_d;
         pend_dp_q     <= pend_dp_d;
         pend_full_q   <= pend_full_d;
         shadow_q      <= shadow_d;
         shadow_dp_q   <= shadow_dp_d;
         val_ready_q   <= ~pend_full_d;
         frame_start_q <= w_frame_evt;
         err_q         <= err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= c_S_IDLE;
         cnt_q   <= 8'd0;
         an_q    <= 4'hF;
         seg_q   <= 7'h7F;
         dp_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         an_q    <= an_d;
         seg_q   <= seg_d;
         dp_q    <= dp_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = err_q | (w_chg & ~w_legal);
      if (w_chg) begin
         if (!w_legal) begin
            state_d = c_S_IDLE;
         end else if (c_BLANK == 8'd0) begin
            state_d = c_S_SHOW;
         end else begin
            state_d = c_S_BLANK;
            cnt_d   = c_BLANK - 8'd1;
         end
      end else if (state_q == c_S_BLANK) begin
         if (cnt_q == 8'd0) state_d = c_S_SHOW;
         else               cnt_d   = cnt_q - 8'd1;
      end
   end

   // w_lz[k]: nibbles k..3 of the shadow are all zero.
   always_comb begin
      w_lz[3] = (shadow_d[15:12] == 4'h0);
      w_lz[2] = w_lz[3] && (shadow_d[11:8] == 4'h0);
      w_lz[1] = w_lz[2] && (shadow_d[7:4] == 4'h0);
      w_lz[0] = 1'b0;
   end

   always_comb begin
      an_d  = 4'hF;
      seg_d = 7'h7F;
      dp_d  = 1'b1;
      if (state_d == c_S_SHOW) begin
         an_d  = s2_q;
         seg_d = (LZB && w_lz[w_dig_idx]) ? 7'h7F
                                          : f_hex7(shadow_d[{w_dig_idx, 2'b00} +: 4]);
         dp_d  = ~shadow_dp_d[w_dig_idx];
      end
   end

   assign val_ready   = val_ready_q;
   assign an          = an_q;
   assign seg         = seg_q;
   assign dp          = dp_q;
   assign frame_start = frame_start_q;
   assign sel_err     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_digit_driver.sv
`default_nettype none
// ============================================================================
// Module  : tb_seg7_digit_driver
// Brief   : Directed scoreboard bench for seg7_digit_driver (BLANK_CYCLES=4).
// Revision: 1.0
// ============================================================================
module tb_seg7_digit_driver;

   localparam int B = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  dig_sel = 4'hF;
   logic [15:0] val_data = 16'h0;
   logic [3:0]  val_dp = 4'h0;
   logic        val_valid = 1'b0;
   logic        val_ready, dp, frame_start, sel_err;
   logic [3:0]  an;
   logic [6:0]  seg;

   seg7_digit_driver #(.BLANK_CYCLES(B), .LZB(1'b1)) dut (
      .clk(clk), .reset(reset), .dig_sel(dig_sel), .val_data(val_data),
      .val_dp(val_dp), .val_valid(val_valid), .val_ready(val_ready),
      .an(an), .seg(seg), .dp(dp), .frame_start(frame_start), .sel_err(sel_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
   } disp_t;

   disp_t       exp_q[$];
   int          n_cmp = 0;
   int          n_fail = 0;
   logic [15:0] m_shadow = 16'h0, m_pend = 16'h0;
   logic [3:0]  m_sdp = 4'h0, m_pdp = 4'h0, m_an = 4'hF;
   logic        m_full = 1'b0, m_err = 1'b0;

   function automatic logic [6:0] hexseg(input logic [3:0] n);
      case (n)
         4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
         4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
         4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
         4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
      endcase
   endfunction

   // Leading-zero rule: digit k>0 dark when the value shifted down by k nibbles is zero.
   function automatic logic [6:0] exp_seg(input logic [15:0] v, input int k);
      if (k > 0 && (v >> (4 * k)) == 16'h0) return 7'h7F;
      return hexseg(v[4 * k +: 4]);
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      logic acc;
      acc = val_valid && !m_full;
      @(posedge clk);
      #1;
      if (acc) begin
         m_pend    = val_data;
         m_pdp     = val_dp;
         m_full    = 1'b1;
         val_valid = 1'b0;
      end
   endtask

   task automatic step(input logic [3:0] sel, input int k);
      disp_t       e;
      logic        fs;
      logic [15:0] nsh;
      logic [3:0]  ndp;
      fs     = (sel == 4'b1110) && m_full;
      nsh    = fs ? m_pend : m_shadow;
      ndp    = fs ? m_pdp : m_sdp;
      e.an   = sel;
      e.seg  = exp_seg(nsh, k);
      e.dp   = ~ndp[k];
      exp_q.push_back(e);
      dig_sel = sel;
      for (int i = 1; i <= 3 + B; i++) begin
         tick();
         if (i == 3) begin
            chk("frame_start", {15'h0, frame_start}, {15'h0, sel == 4'b1110});
            if (fs) begin
               m_shadow = nsh;
               m_sdp    = ndp;
               m_full   = 1'b0;
            end
         end else begin
            chk("frame_start_quiet", {15'h0, frame_start}, 16'h0);
         end
         chk("val_ready", {15'h0, val_ready}, {15'h0, !m_full});
         if (i < 3)          chk("an_hold", {12'h0, an}, {12'h0, m_an});
         else if (i < 3 + B) chk("an_blank", {12'h0, an}, 16'h000F);
      end
      e = exp_q.pop_front();
      chk("an_show", {12'h0, an}, {12'h0, e.an});
      chk("seg", {9'h0, seg}, {9'h0, e.seg});
      chk("dp", {15'h0, dp}, {15'h0, e.dp});
      chk("sel_err", {15'h0, sel_err}, {15'h0, m_err});
      m_an = sel;
   endtask

   task automatic step_illegal(input logic [3:0] sel);
      dig_sel = sel;
      for (int i = 1; i <= 3; i++) begin
         tick();
         if (i < 3) chk("an_hold_ill", {12'h0, an}, {12'h0, m_an});
      end
      m_err = 1'b1;
      m_an  = 4'hF;
      chk("an_illegal", {12'h0, an}, 16'h000F);
      chk("seg_illegal", {9'h0, seg}, 16'h007F);
      chk("dp_illegal", {15'h0, dp}, 16'h0001);
      chk("sel_err_set", {15'h0, sel_err}, 16'h0001);
   endtask

   task automatic reset_and_check(input string tag);
      reset = 1'b0;
      tick();
      m_shadow = 16'h0; m_sdp = 4'h0; m_full = 1'b0; m_err = 1'b0; m_an = 4'hF;
      chk({tag, "_an"}, {12'h0, an}, 16'h000F);
      chk({tag, "_seg"}, {9'h0, seg}, 16'h007F);
      chk({tag, "_dp"}, {15'h0, dp}, 16'h0001);
      chk({tag, "_val_ready"}, {15'h0, val_ready}, 16'h0001);
      chk({tag, "_frame_start"}, {15'h0, frame_start}, 16'h0);
      chk({tag, "_sel_err"}, {15'h0, sel_err}, 16'h0);
      reset = 1'b1;
   endtask

   initial begin
      tick();
      reset_and_check("reset");

      // Zero value: only digit 0 lit.
      step(4'b1110, 0); step(4'b1101, 1); step(4'b1011, 2); step(4'b0111, 3);

      // Mid-frame load is held back until the next digit-0 entry.
      step(4'b1110, 0); step(4'b1101, 1);
      val_data = 16'h12AF; val_dp = 4'b0101; val_valid = 1'b1;
      step(4'b1011, 2); step(4'b0111, 3);
      step(4'b1110, 0); step(4'b1101, 1); step(4'b1011, 2); step(4'b0111, 3);

      // Illegal select, then a legal one; the error flag stays sticky.
      step_illegal(4'b0001);
      step(4'b1101, 1);

      // Second offer held while the pending slot is full.
      val_data = 16'h00A5; val_dp = 4'b0000; val_valid = 1'b1;
      step(4'b1011, 2);
      val_data = 16'h0300; val_dp = 4'b1000; val_valid = 1'b1;
      step(4'b0111, 3);
      step(4'b1110, 0); step(4'b1101, 1); step(4'b1011, 2); step(4'b0111, 3);
      step(4'b1110, 0); step(4'b1101, 1); step(4'b1011, 2); step(4'b0111, 3);

      // Reset while showing with a value pending; that value is discarded.
      val_data = 16'hBEEF; val_dp = 4'hF; val_valid = 1'b1;
      step(4'b1101, 1);
      reset_and_check("reset_mid");
      step(4'b1110, 0); step(4'b1101, 1); step(4'b1110, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
